cpu_memory: RTL and testbench

Word-organised memory responder that serves the pipelined CPU's instruction bus and data bus. It returns fetched instructions and load data one cycle after the CPU presents an address, and commits stores on the sampling edge. A post-reset clear sweep and a streaming program-load port let the bench or boot logic initialise the memory without hierarchical access.

---
 rtl/cpu_memory.sv | 143 ++++++++++++++
 tb/tb_cpu_memory.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_memory.sv
// Word-organised memory serving the CPU instruction and data buses, with a post-reset
// clear sweep and a streaming program-load port.
module cpu_memory #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_pc,
    output logic [31:0] o_instruction,
    input  logic [15:0] i_address,
    input  logic        i_rw,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_ready,
    input  logic        i_load_start,
    input  logic        i_load_valid,
    input  logic [31:0] i_load_data,
    input  logic        i_load_last,
    output logic        o_load_ready,
    output logic        o_fault,
    output logic [15:0] o_fault_addr
);

    localparam int unsigned Depth  = 1 << ADDR_BITS;
    localparam logic [15:0] HiMask = 16'hFFFF << (ADDR_BITS + 2);

    typedef enum logic [1:0] {StClear, StServe, StLoad} state_e;

    state_e                 state_q;
    logic [ADDR_BITS-1:0]   ptr_q;
    logic [31:0]            instr_q;
    logic [31:0]            rdata_q;
    logic                   ready_q;
    logic                   load_ready_q;
    logic                   fault_q;
    logic [15:0]            fault_addr_q;

    logic [31:0]            mem [Depth];

    logic                   pc_bad;
    logic                   data_bad;
    logic [ADDR_BITS-1:0]   pc_idx;
    logic [ADDR_BITS-1:0]   data_idx;

    logic                   we;
    logic [ADDR_BITS-1:0]   waddr;
    logic [31:0]            wdata;

    assign pc_bad   = (|i_pc[1:0]) || (|(i_pc & HiMask));
    assign data_bad = (|i_address[1:0]) || (|(i_address & HiMask));
    assign pc_idx   = i_pc[ADDR_BITS+1:2];
    assign data_idx = i_address[ADDR_BITS+1:2];

    // Single write port shared by the clear sweep, the load stream and CPU stores.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state_q)
            StClear: begin
                we    = 1'b1;
                waddr = ptr_q;
            end
            StLoad: begin
                we    = i_load_valid;
                waddr = ptr_q;
                wdata = i_load_data;
            end
            StServe: begin
                we    = !i_rw && !data_bad;
                waddr = data_idx;
                wdata = i_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads sample the array with non-blocking semantics, so a same-cycle write is not seen.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= StClear;
            ptr_q        <= '0;
            instr_q      <= '0;
            rdata_q      <= '0;
            ready_q      <= 1'b0;
            load_ready_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            case (state_q)
                StClear: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (&ptr_q) begin
                        state_q <= StServe;
                        ready_q <= 1'b1;
                    end
                end
                StServe: begin
                    instr_q <= pc_bad ? '0 : mem[pc_idx];
                    if (i_rw) begin
                        rdata_q <= data_bad ? '0 : mem[data_idx];
                    end
                    if (!fault_q && (pc_bad || data_bad)) begin
                        fault_q      <= 1'b1;
                        fault_addr_q <= data_bad ? i_address : i_pc;
                    end
                    if (i_load_start) begin
                        state_q      <= StLoad;
                        ptr_q        <= '0;
                        ready_q      <= 1'b0;
                        load_ready_q <= 1'b1;
                    end
                end
                StLoad: begin
                    if (i_load_valid) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (i_load_last || (&ptr_q)) begin
                            state_q      <= StServe;
                            ready_q      <= 1'b1;
                            load_ready_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

    // Bus outputs are forced to zero whenever the memory is not serving the CPU.
    assign o_instruction = ready_q ? instr_q : '0;
    assign o_data        = ready_q ? rdata_q : '0;
    assign o_ready       = ready_q;
    assign o_load_ready  = load_ready_q;
    assign o_fault       = fault_q;
    assign o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_cpu_memory.sv
// Scoreboard bench for cpu_memory: the driver queues expected values with a due cycle,
// a negedge monitor pops and compares them.
module tb_cpu_memory;

    localparam int unsigned AB = 4;

    localparam int KInstr     = 0;
    localparam int KData      = 1;
    localparam int KReady     = 2;
    localparam int KLoadReady = 3;
    localparam int KFault     = 4;
    localparam int KFaultAddr = 5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] pc;
    logic [31:0] instruction;
    logic [15:0] address;
    logic        rw;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        fault;
    logic [15:0] fault_addr;

    cpu_memory #(.ADDR_BITS(AB)) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_pc          (pc),
        .o_instruction (instruction),
        .i_address     (address),
        .i_rw          (rw),
        .i_data        (wdata),
        .o_data        (rdata),
        .o_ready       (ready),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .i_load_last   (load_last),
        .o_load_ready  (load_ready),
        .o_fault       (fault),
        .o_fault_addr  (fault_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int due, input int kind, input logic [31:0] exp,
                             input string name);
        chk_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every entry due in the current cycle against the live outputs.
    always @(negedge clk) begin
        logic [31:0] act;
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    KInstr:     act = instruction;
                    KData:      act = rdata;
                    KReady:     act = {31'd0, ready};
                    KLoadReady: act = {31'd0, load_ready};
                    KFault:     act = {31'd0, fault};
                    default:    act = {16'd0, fault_addr};
                endcase
                total++;
                if (sb[i].due < cyc) begin
                    $display("FAIL %s: check missed its cycle (due %0d, now %0d)",
                             sb[i].name, sb[i].due, cyc);
                end else if (act === sb[i].exp) begin
                    passed++;
                end else begin
                    $display("FAIL %s: got %h, expected %h (cycle %0d)",
                             sb[i].name, act, sb[i].exp, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic reset_state_checks();
        expect_at(cyc, KReady, 32'd0, "rst_ready");
        expect_at(cyc, KLoadReady, 32'd0, "rst_load_ready");
        expect_at(cyc, KInstr, 32'd0, "rst_instr");
        expect_at(cyc, KData, 32'd0, "rst_data");
        expect_at(cyc, KFault, 32'd0, "rst_fault");
        expect_at(cyc, KFaultAddr, 32'd0, "rst_fault_addr");
    endtask

    // Release reset and expect exactly 16 cycles of o_ready low.
    task automatic release_and_sweep();
        int r;
        reset_n = 1'b1;
        r = cyc;
        for (int d = 0; d <= 16; d++) begin
            expect_at(r + d, KReady, (d == 16) ? 32'd1 : 32'd0, "clear_ready");
        end
        repeat (16) tick();
    endtask

    task automatic fetch(input logic [15:0] a, input logic [31:0] exp, input string name);
        pc = a;
        expect_at(cyc + 1, KInstr, exp, name);
        tick();
    endtask

    task automatic pulse_load_start();
        load_start = 1'b1;
        expect_at(cyc + 1, KLoadReady, 32'd1, "enter_load");
        expect_at(cyc + 1, KReady, 32'd0, "enter_load_ready");
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        pc         = '0;
        address    = '0;
        rw         = 1'b1;
        wdata      = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;

        repeat (2) tick();
        reset_state_checks();
        tick();
        release_and_sweep();

        for (int w = 0; w < 16; w++) begin
            fetch(16'(w * 4), 32'h0, "cleared_word");
        end

        // Program load of three words.
        pulse_load_start();
        for (int j = 0; j < 3; j++) begin
            load_valid = 1'b1;
            load_data  = 32'h11111111 * (j + 1);
            load_last  = (j == 2);
            expect_at(cyc + 1, KReady, (j == 2) ? 32'd1 : 32'd0, "load_ready_low");
            expect_at(cyc + 1, KLoadReady, (j == 2) ? 32'd0 : 32'd1, "load_port_ready");
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        fetch(16'h0000, 32'h11111111, "load_word0");
        fetch(16'h0004, 32'h22222222, "load_word1");
        fetch(16'h0008, 32'h33333333, "load_word2");

        // Store with a same-cycle fetch of the same word (read-first), o_data holds.
        address = 16'h0008;
        rw      = 1'b0;
        wdata   = 32'hDEADBEEF;
        pc      = 16'h0008;
        expect_at(cyc + 1, KInstr, 32'h33333333, "read_first_fetch");
        expect_at(cyc + 1, KData, 32'h11111111, "store_holds_data");
        tick();
        rw = 1'b1;
        expect_at(cyc + 1, KData, 32'hDEADBEEF, "read_after_write");
        expect_at(cyc + 1, KInstr, 32'hDEADBEEF, "fetch_after_write");
        tick();

        // Faults: misaligned read first, then an out-of-range store that must be dropped.
        expect_at(cyc, KFault, 32'd0, "no_fault_yet");
        address = 16'h0006;
        pc      = 16'h0000;
        expect_at(cyc + 1, KData, 32'd0, "misaligned_read");
        expect_at(cyc + 1, KFault, 32'd1, "fault_set");
        expect_at(cyc + 1, KFaultAddr, 32'h0006, "fault_addr");
        tick();
        address = 16'h0100;
        rw      = 1'b0;
        wdata   = 32'hCAFEF00D;
        expect_at(cyc + 1, KFaultAddr, 32'h0006, "fault_addr_sticky");
        tick();
        rw      = 1'b1;
        address = 16'h0000;
        expect_at(cyc + 1, KData, 32'h11111111, "oor_write_dropped");
        tick();
        fetch(16'h0002, 32'h0, "misaligned_fetch");
        pc = 16'h0000;

        // Load overflow: 20 words without last, only words 0-15 land.
        pulse_load_start();
        for (int j = 0; j < 20; j++) begin
            load_valid = 1'b1;
            load_data  = 32'hA0000000 + j;
            expect_at(cyc + 1, KLoadReady, (j < 15) ? 32'd1 : 32'd0, "ovf_load_ready");
            expect_at(cyc + 1, KReady, (j < 15) ? 32'd0 : 32'd1, "ovf_ready");
            tick();
        end
        load_valid = 1'b0;
        for (int w = 0; w < 16; w++) begin
            fetch(16'(w * 4), 32'hA0000000 + w, "ovf_word");
        end

        // Reset in the middle of a load.
        pulse_load_start();
        for (int j = 0; j < 2; j++) begin
            load_valid = 1'b1;
            load_data  = 32'h55555555 + j;
            tick();
        end
        load_valid = 1'b0;
        reset_n    = 1'b0;
        reset_state_checks();
        tick();
        release_and_sweep();
        fetch(16'h0000, 32'h0, "post_reset_word0");
        fetch(16'h0004, 32'h0, "post_reset_word1");

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            tick();
        end
        if (sb.size() > 0) begin
            total++;
            $display("FAIL drain: %0d checks left pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
